// File: rtl/multicycle_rtype_control_if.sv
// Instruction/control bus of the multicycle R-type control unit.
//   master : instruction source. It drives instr_valid and function_code
//            and observes the control outputs.
//   slave  : the control unit. It samples the instruction and drives
//            instr_ready, select_bits_ALU, alu_en, reg_write, done,
//            illegal_funct, busy and retired_count.
interface multicycle_rtype_control_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [5:0]       function_code;
    logic [2:0]       select_bits_ALU;
    logic             alu_en;
    logic             reg_write;
    logic             done;
    logic             illegal_funct;
    logic             busy;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output instr_valid, function_code,
        input  instr_ready, select_bits_ALU, alu_en, reg_write, done,
               illegal_funct, busy, retired_count
    );

    modport slave (
        input  instr_valid, function_code,
        output instr_ready, select_bits_ALU, alu_en, reg_write, done,
               illegal_funct, busy, retired_count
    );
endinterface

// File: rtl/multicycle_rtype_control.sv
// Multicycle control unit for the R-type MIPS datapath.
// Accepts one funct code per instruction (valid/ready) and sequences it
// through DECODE -> EXECUTE (N cycles) -> WRITEBACK. N is EXEC_CYCLES, or
// SHIFT_CYCLES for srl. It also flags unsupported codes and counts
// retired instructions.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : slave side of multicycle_rtype_control_if (handshake in,
//            ALU select / strobes / status / retired count out)
// Every output is a flop, so the strobes are glitch-free and mutually
// exclusive by construction.
module multicycle_rtype_control #(
    parameter int EXEC_CYCLES  = 1,
    parameter int SHIFT_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_rtype_control_if.slave   bus
);

    localparam int MAXC = (EXEC_CYCLES > SHIFT_CYCLES) ? EXEC_CYCLES : SHIFT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    state_t      state;
    logic [5:0]  funct_q;
    logic [CW-1:0] cyc_cnt;

    function automatic logic legal_of(input logic [5:0] f);
        case (f)
            6'h24, 6'h25, 6'h20, 6'h2A,
            6'h22, 6'h02, 6'h26, 6'h27: legal_of = 1'b1;
            default:                    legal_of = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] sel_of(input logic [5:0] f);
        case (f)
            6'h24:   sel_of = 3'b000;  // and
            6'h25:   sel_of = 3'b001;  // or
            6'h20:   sel_of = 3'b010;  // add
            6'h2A:   sel_of = 3'b011;  // slt
            6'h22:   sel_of = 3'b100;  // sub
            6'h02:   sel_of = 3'b101;  // srl
            6'h26:   sel_of = 3'b110;  // xor
            6'h27:   sel_of = 3'b111;  // nor
            default: sel_of = 3'b000;
        endcase
    endfunction

    logic       in_legal;
    logic       lat_legal;
    logic [2:0] lat_sel;
    logic       lat_srl;

    assign in_legal  = legal_of(bus.function_code);
    assign lat_legal = legal_of(funct_q);
    assign lat_sel   = sel_of(funct_q);
    assign lat_srl   = (funct_q == 6'h02);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            funct_q             <= 6'd0;
            cyc_cnt             <= '0;
            bus.instr_ready     <= 1'b0;
            bus.select_bits_ALU <= 3'b000;
            bus.alu_en          <= 1'b0;
            bus.reg_write       <= 1'b0;
            bus.done            <= 1'b0;
            bus.illegal_funct   <= 1'b0;
            bus.busy            <= 1'b0;
            bus.retired_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // instr_ready is low only in the first cycle after reset.
                    // The first edge raises it, and acceptance needs it high.
                    if (bus.instr_ready && bus.instr_valid) begin
                        funct_q           <= bus.function_code;
                        state             <= DECODE;
                        bus.instr_ready   <= 1'b0;
                        bus.busy          <= 1'b1;
                        // Legality of the accepted code is computed here so
                        // the flag is a flop that is high for the whole DECODE cycle.
                        bus.illegal_funct <= ~in_legal;
                    end else begin
                        bus.instr_ready   <= 1'b1;
                    end
                end

                DECODE: begin
                    bus.illegal_funct <= 1'b0;
                    if (lat_legal) begin
                        bus.select_bits_ALU <= lat_sel;
                        cyc_cnt  <= lat_srl ? CW'(SHIFT_CYCLES) : CW'(EXEC_CYCLES);
                        bus.alu_en <= 1'b1;
                        state    <= EXECUTE;
                    end else begin
                        // Unsupported code: select and count stay unchanged.
                        bus.instr_ready <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end
                end

                EXECUTE: begin
                    cyc_cnt <= cyc_cnt - CW'(1);
                    // A count of 1 means this is the last EXECUTE cycle.
                    if (cyc_cnt == CW'(1)) begin
                        bus.alu_en    <= 1'b0;
                        bus.reg_write <= 1'b1;
                        bus.done      <= 1'b1;
                        state         <= WRITEBACK;
                    end
                end

                WRITEBACK: begin
                    bus.reg_write     <= 1'b0;
                    bus.done          <= 1'b0;
                    bus.retired_count <= bus.retired_count + CNT_W'(1);
                    bus.instr_ready   <= 1'b1;
                    bus.busy          <= 1'b0;
                    state             <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_rtype_control.sv
module tb_multicycle_rtype_control;

    localparam int EXEC  = 1;
    localparam int SHIFT = 3;
    localparam int CW    = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_rtype_control_if #(.CNT_W(CW)) bus ();

    multicycle_rtype_control #(
        .EXEC_CYCLES (EXEC),
        .SHIFT_CYCLES(SHIFT),
        .CNT_W       (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position of the current instruction on its
    // timeline. ph=0 means idle. Otherwise ph is the cycle number after
    // acceptance: 1 is decode, 2..1+N is execute, and 2+N is writeback.
    int         ph;
    int         n_cur;
    bit         leg;
    logic [2:0] pend_sel;
    logic [2:0] sel_m;
    int         cnt_m;
    bit         rdy_m;
    int         cyc;
    logic       last_rdy;

    logic [5:0] legal_tab [8] = '{6'h24, 6'h25, 6'h20, 6'h2A, 6'h22, 6'h02, 6'h26, 6'h27};

    function automatic int ref_sel(input logic [5:0] f);
        case (f)
            6'h24: return 0;
            6'h25: return 1;
            6'h20: return 2;
            6'h2A: return 3;
            6'h22: return 4;
            6'h02: return 5;
            6'h26: return 6;
            6'h27: return 7;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        ph = 0; n_cur = 0; leg = 0; pend_sel = 3'd0; sel_m = 3'd0; cnt_m = 0; rdy_m = 0;
    endtask

    task automatic model_update(input bit v, input logic [5:0] f);
        int s;
        if (ph == 0) begin
            if (rdy_m && v) begin
                s = ref_sel(f);
                ph = 1;
                leg = (s >= 0);
                pend_sel = s[2:0];
                n_cur = (f == 6'h02) ? SHIFT : EXEC;
            end
            rdy_m = 1;
        end else if (ph == 1) begin
            if (leg) begin
                ph = 2;
                sel_m = pend_sel;
            end else begin
                ph = 0;
            end
        end else if (ph == 2 + n_cur) begin
            ph = 0;
            cnt_m = (cnt_m + 1) % (1 << CW);
        end else begin
            ph++;
        end
    endtask

    task automatic check_all();
        bit in_ex;
        bit in_wb;
        in_ex = leg && ph >= 2 && ph <= 1 + n_cur;
        in_wb = leg && ph == 2 + n_cur;
        chk("instr_ready",   32'(bus.instr_ready),     32'(rdy_m && ph == 0));
        chk("busy",          32'(bus.busy),            32'(ph != 0));
        chk("illegal_funct", 32'(bus.illegal_funct),   32'(ph == 1 && !leg));
        chk("alu_en",        32'(bus.alu_en),          32'(in_ex));
        chk("reg_write",     32'(bus.reg_write),       32'(in_wb));
        chk("done",          32'(bus.done),            32'(in_wb));
        chk("select",        32'(bus.select_bits_ALU), 32'(sel_m));
        chk("retired_count", 32'(bus.retired_count),   32'(cnt_m));
    endtask

    task automatic cycle(input bit v, input logic [5:0] f);
        @(negedge clk);
        check_all();
        last_rdy = bus.instr_ready;
        bus.instr_valid = v;
        bus.function_code = f;
        @(posedge clk);
        if (!reset) model_update(v, f);
        cyc++;
    endtask

    // Issue one instruction, then randomize valid/funct until the unit
    // is idle again. Valid is randomized only while the unit is busy.
    task automatic issue(input logic [5:0] f);
        int guard;
        guard = 0;
        while (!(ph == 0 && rdy_m) && guard < 50) begin
            cycle(1'b0, 6'($urandom));
            guard++;
        end
        cycle(1'b1, f);
        while (ph != 0 && guard < 100) begin
            cycle(1'($urandom), 6'($urandom));
            guard++;
        end
        if (guard >= 100) chk("issue_timeout", 32'(guard), 32'(0));
    endtask

    logic [5:0] stream [5] = '{6'h24, 6'h25, 6'h2A, 6'h22, 6'h26};
    int         wrap_seq [5] = '{1, 2, 3, 0, 1};

    initial begin
        int idx;
        int guard;
        int last_acc;
        bit acc;
        logic [5:0] f;

        cyc = 0;
        bus.instr_valid = 1'b0;
        bus.function_code = 6'd0;
        model_reset();

        // Reset held for 3 cycles, then released between edges.
        repeat (3) cycle(1'b1, 6'h20);
        #2 reset = 1'b0;

        // Directed single instructions.
        issue(6'h20);  // add
        issue(6'h02);  // srl: SHIFT_CYCLES of EXECUTE
        issue(6'h27);  // nor
        issue(6'h00);  // illegal: select must stay 111
        #1 chk("sel_hold_after_illegal", 32'(bus.select_bits_ALU), 32'(3'b111));

        // Back-to-back with valid held high. funct toggles while busy.
        idx = 0; guard = 0; last_acc = -1;
        while (idx < 5 && guard < 100) begin
            f = (ph == 0) ? stream[idx] : 6'($urandom);
            cycle(1'b1, f);
            acc = last_rdy;
            if (acc) begin
                if (last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'(3 + EXEC));
                last_acc = cyc;
                idx++;
            end
            guard++;
        end
        if (guard >= 100) chk("b2b_timeout", 32'(idx), 32'(5));
        guard = 0;
        while (ph != 0 && guard < 50) begin
            cycle(1'b0, 6'($urandom));
            guard++;
        end

        // Random traffic, mixing legal and arbitrary codes.
        repeat (400) begin
            if ($urandom_range(0, 1) == 1) f = legal_tab[$urandom_range(0, 7)];
            else f = 6'($urandom);
            cycle(1'($urandom_range(0, 1)), f);
        end
        guard = 0;
        while (ph != 0 && guard < 50) begin
            cycle(1'b0, 6'd0);
            guard++;
        end

        // Reset asserted between edges during EXECUTE of an add.
        cycle(1'b0, 6'd0);
        cycle(1'b1, 6'h20);   // accept
        cycle(1'b0, 6'd0);    // DECODE -> EXECUTE edge
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        chk("async_alu_en", 32'(bus.alu_en), 32'(0));
        cycle(1'b1, 6'h20);
        cycle(1'b1, 6'h20);
        #2 reset = 1'b0;
        cycle(1'b0, 6'd0);
        #1 chk("count_after_reset", 32'(bus.retired_count), 32'(0));

        // Counter wrap with CNT_W=2, with one illegal code in the middle.
        for (int k = 0; k < 5; k++) begin
            issue(legal_tab[$urandom_range(0, 7)]);
            #1 chk("wrap_seq", 32'(bus.retired_count), 32'(wrap_seq[k]));
            if (k == 2) begin
                issue(6'h3F);
                #1 chk("illegal_no_count", 32'(bus.retired_count), 32'(wrap_seq[k]));
            end
        end
        repeat (3) cycle(1'b0, 6'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
